avl_read_stream_buffer: RTL and testbench

- Avalon-MM read master and elastic buffer directly downstream of the DDR3 Avalon bus test/controller port.
- Fetches a contiguous run of DATA_W-bit words from DDR3 starting at a given word address.
- Buffers the returned words in an internal FIFO and streams them to the compute datapath (kernel/ALU loaders) over a valid/ready interface.
- Read issue is credit-limited so the FIFO can never overflow, regardless of consumer back-pressure.

---
 rtl/avl_read_stream_buffer.sv | 168 ++++++++++++++++
 tb/tb_avl_read_stream_buffer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/avl_read_stream_buffer.sv
// Avalon-MM burst-free read master feeding a first-word-fall-through FIFO.
// Reads are issued only when the FIFO is guaranteed room for every reply in flight.
module avl_read_stream_buffer #(
   parameter int ADDR_W     = 26,
   parameter int DATA_W     = 128,
   parameter int LEN_W      = 16,
   parameter int FIFO_DEPTH = 16
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              local_init_done,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  word_count,
   output logic              busy,
   output logic              done,
   output logic              err_stray,
   input  logic              avl_waitrequest_n,
   output logic [ADDR_W-1:0] avl_address,
   output logic              avl_read,
   output logic              avl_burstbegin,
   input  logic              avl_readdatavalid,
   input  logic [DATA_W-1:0] avl_readdata,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              rd_ready
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  issue_left_q, issue_left_d;
   logic [LEN_W-1:0]  deliver_left_q, deliver_left_d;
   logic [CNT_W-1:0]  outstanding_q, outstanding_d;
   logic [CNT_W-1:0]  fifo_count_q, fifo_count_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic              read_q, read_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];

   logic              accept;
   logic              push;
   logic              pop;
   logic              stray;
   logic              start_ok;
   logic [CNT_W:0]    inflight;
   logic [LEN_W-1:0]  issue_after;

   assign accept      = read_q & avl_waitrequest_n;
   assign push        = avl_readdatavalid & (outstanding_q != '0);
   assign stray       = avl_readdatavalid & (outstanding_q == '0);
   assign pop         = (fifo_count_q != '0) & rd_ready;
   assign start_ok    = (state_q == IDLE) & start & local_init_done;
   assign issue_after = issue_left_q - LEN_W'(accept);

   // A read accepted this cycle is not yet in outstanding_q, so count it here
   // to avoid issuing one read too many.
   assign inflight = (CNT_W + 1)'(fifo_count_q) + (CNT_W + 1)'(outstanding_q)
                   + (CNT_W + 1)'(accept);

   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      issue_left_d   = issue_left_q;
      deliver_left_d = deliver_left_q;
      outstanding_d  = outstanding_q + CNT_W'(accept) - CNT_W'(push);
      fifo_count_d   = fifo_count_q + CNT_W'(push) - CNT_W'(pop);
      wr_ptr_d       = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d       = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      read_d         = 1'b0;
      err_d          = err_q | stray;

      if (pop && deliver_left_q != '0)
         deliver_left_d = deliver_left_q - LEN_W'(1);
      if (accept) begin
         addr_d       = addr_q + ADDR_W'(1);
         issue_left_d = issue_after;
      end

      case (state_q)
         IDLE: begin
            if (start_ok) begin
               addr_d         = base_addr;
               issue_left_d   = word_count;
               deliver_left_d = word_count;
               err_d          = stray;
               if (word_count != '0) begin
                  state_d = ISSUE;
                  read_d  = 1'b1;
               end else begin
                  state_d = FIN;
               end
            end
         end
         ISSUE: begin
            // An unaccepted request must be held regardless of credit.
            if (read_q && !avl_waitrequest_n)
               read_d = 1'b1;
            else
               read_d = (issue_after != '0) && (inflight < DEPTH_V);
            if (accept && issue_after == '0)
               state_d = DRAIN;
         end
         DRAIN: begin
            if (deliver_left_d == '0)
               state_d = FIN;
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == ISSUE) || (state_d == DRAIN);
      done_d = (state_d == FIN);
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q        <= IDLE;
         addr_q         <= '0;
         issue_left_q   <= '0;
         deliver_left_q <= '0;
         outstanding_q  <= '0;
         fifo_count_q   <= '0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         read_q         <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         addr_q         <= addr_d;
         issue_left_q   <= issue_left_d;
         deliver_left_q <= deliver_left_d;
         outstanding_q  <= outstanding_d;
         fifo_count_q   <= fifo_count_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         read_q         <= read_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         err_q          <= err_d;
      end
   end

   always_ff @(posedge iCLK) begin
      if (push)
         mem[wr_ptr_q] <= avl_readdata;
   end

   assign avl_address    = addr_q;
   assign avl_read       = read_q;
   assign avl_burstbegin = read_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign err_stray      = err_q;
   assign rd_valid       = (fifo_count_q != '0);
   // Gate the head so stale RAM contents never show while the FIFO is empty.
   assign rd_data        = rd_valid ? mem[rd_ptr_q] : '0;
endmodule

// File: tb/tb_avl_read_stream_buffer.sv
// Randomized bench: Avalon slave model with in-order replies plus an
// address-sequence scoreboard for the issued reads and the streamed words.
module tb_avl_read_stream_buffer;
   localparam int ADDR_W = 26;
   localparam int DATA_W = 128;
   localparam int LEN_W  = 16;
   localparam int DEPTH  = 16;

   logic              iCLK;
   logic              iRST;
   logic              local_init_done;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [LEN_W-1:0]  word_count;
   logic              busy;
   logic              done;
   logic              err_stray;
   logic              avl_waitrequest_n;
   logic [ADDR_W-1:0] avl_address;
   logic              avl_read;
   logic              avl_burstbegin;
   logic              avl_readdatavalid;
   logic [DATA_W-1:0] avl_readdata;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              rd_ready;

   avl_read_stream_buffer #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)
   ) dut (
      .iCLK(iCLK), .iRST(iRST), .local_init_done(local_init_done),
      .start(start), .base_addr(base_addr), .word_count(word_count),
      .busy(busy), .done(done), .err_stray(err_stray),
      .avl_waitrequest_n(avl_waitrequest_n), .avl_address(avl_address),
      .avl_read(avl_read), .avl_burstbegin(avl_burstbegin),
      .avl_readdatavalid(avl_readdatavalid), .avl_readdata(avl_readdata),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready)
   );

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                           input logic [DATA_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] data_of(input logic [ADDR_W-1:0] a);
      logic [31:0] w;
      w = 32'(a);
      return {w ^ 32'hA5A5_0000, w, ~w, w * 32'd7};
   endfunction

   typedef struct {
      int                due;
      logic [ADDR_W-1:0] addr;
   } rsp_t;

   rsp_t              rsp_q[$];
   int                cyc = 0;
   int                wr_low_pct = 0;
   int                lat_lo = 2;
   int                lat_hi = 2;
   int                ready_pct = 100;
   int                stall_until = 0;
   logic [ADDR_W-1:0] exp_base;
   int                n_acc, n_ret, n_pop, occ;
   int                done_cnt, done_cyc, last_pop_cyc;
   bit                hold_pend = 0;
   logic [ADDR_W-1:0] hold_addr;

   // One cycle of slave + consumer behaviour, called just after a falling edge.
   task automatic step();
      bit                acc, push, pop;
      logic [ADDR_W-1:0] ea;
      if (hold_pend) begin
         check_eq("hold_read", avl_read, 1'b1);
         check_eq("hold_addr", avl_address, hold_addr);
      end
      check_eq("rd_valid", rd_valid, occ != 0);
      check_eq("burstbegin", avl_burstbegin, avl_read);
      check_eq("credit", (occ + n_acc - n_ret) <= DEPTH, 1'b1);
      if (stall_until != 0 && cyc == stall_until - 1) begin
         check_eq("stall_acc", n_acc, 16);
         check_eq("stall_read", avl_read, 1'b0);
         check_eq("stall_full", occ, 16);
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      avl_waitrequest_n = ($urandom_range(99) >= wr_low_pct);
      rd_ready = (cyc < stall_until) ? 1'b0 : ($urandom_range(99) < ready_pct);
      acc = avl_read && avl_waitrequest_n;
      if (acc) begin
         ea = exp_base + ADDR_W'(n_acc);
         check_eq("acc_addr", avl_address, ea);
         rsp_q.push_back('{cyc + $urandom_range(lat_hi, lat_lo), avl_address});
         n_acc++;
      end
      hold_pend = avl_read && !avl_waitrequest_n;
      hold_addr = avl_address;
      pop = rd_valid && rd_ready;
      if (pop) begin
         ea = exp_base + ADDR_W'(n_pop);
         check_eq("rd_data", rd_data, data_of(ea));
         n_pop++;
         last_pop_cyc = cyc;
      end
      push = 0;
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
         avl_readdatavalid = 1'b1;
         avl_readdata      = data_of(rsp_q[0].addr);
         void'(rsp_q.pop_front());
         n_ret++;
         push = 1;
      end else begin
         avl_readdatavalid = 1'b0;
      end
      occ += int'(push) - int'(pop);
      cyc++;
   endtask

   task automatic run_xfer(input logic [ADDR_W-1:0] b, input int n, input int restart_at);
      int k, t0, lat;
      bit fin;
      exp_base = b;
      n_acc = 0; n_ret = 0; n_pop = 0;
      done_cnt = 0; done_cyc = 0; last_pop_cyc = 0;
      @(negedge iCLK);
      step();
      start = 1'b1; base_addr = b; word_count = LEN_W'(n);
      t0 = cyc - 1;
      k = 0; fin = 0;
      while (!fin && k < 3000) begin
         @(negedge iCLK);
         if (k == 0) begin
            start = 1'b0;
            check_eq("busy_on", busy, n != 0);
            check_eq("err_clear", err_stray, 1'b0);
         end
         if (k == restart_at) begin
            start = 1'b1; base_addr = b ^ 26'h40; word_count = 16'd7;
         end
         if (k == restart_at + 1) start = 1'b0;
         step();
         k++;
         fin = (done_cnt > 0) && (cyc > done_cyc + 3);
      end
      lat = done_cyc - ((n == 0) ? t0 : last_pop_cyc);
      check_eq("xfer_timeout", k < 3000, 1'b1);
      check_eq("acc_count", n_acc, n);
      check_eq("pop_count", n_pop, n);
      check_eq("done_pulses", done_cnt, 1);
      check_eq("done_lat", (lat == 1) || (lat == 2), 1'b1);
      check_eq("busy_idle", busy, 1'b0);
      check_eq("err_stray", err_stray, 1'b0);
      $display("xfer base=%h n=%0d acc=%0d pop=%0d done_lat=%0d", b, n, n_acc, n_pop, lat);
   endtask

   initial begin
      int k;
      iRST = 1'b1; local_init_done = 1'b0; start = 1'b0;
      base_addr = '0; word_count = '0; avl_waitrequest_n = 1'b1;
      avl_readdatavalid = 1'b0; avl_readdata = '0; rd_ready = 1'b0;
      repeat (3) @(negedge iCLK);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_done", done, 1'b0);
      check_eq("rst_read", avl_read, 1'b0);
      check_eq("rst_addr", avl_address, '0);
      check_eq("rst_valid", rd_valid, 1'b0);
      check_eq("rst_err", err_stray, 1'b0);
      check_eq("rst_data", rd_data, '0);
      iRST = 1'b0;

      // Start before calibration completes must be ignored.
      @(negedge iCLK);
      start = 1'b1; base_addr = 26'h55; word_count = 16'd3;
      @(negedge iCLK);
      start = 1'b0;
      check_eq("noinit_busy", busy, 1'b0);
      @(negedge iCLK);
      check_eq("noinit_read", avl_read, 1'b0);
      local_init_done = 1'b1;

      run_xfer(26'h100, 4, -1);

      wr_low_pct = 20; lat_lo = 1; lat_hi = 5; ready_pct = 80;
      stall_until = cyc + 200;
      run_xfer(26'h2000, 40, -1);
      stall_until = 0;

      wr_low_pct = 50; lat_lo = 1; lat_hi = 6; ready_pct = 100;
      run_xfer(26'h1234, 20, -1);

      wr_low_pct = 0; lat_lo = 2; lat_hi = 2;
      run_xfer(26'h3FFFFFE, 4, -1);

      run_xfer(26'h500, 0, -1);
      wr_low_pct = 30; lat_lo = 1; lat_hi = 4; ready_pct = 60;
      run_xfer(26'h600, 10, 3);

      for (int i = 0; i < 4; i++) begin
         wr_low_pct = $urandom_range(60);
         lat_lo = 1; lat_hi = $urandom_range(10, 1);
         ready_pct = $urandom_range(100, 30);
         run_xfer(ADDR_W'($urandom), $urandom_range(30, 1), -1);
      end

      // Reset with three reads outstanding; their late replies must be strays.
      wr_low_pct = 0; lat_lo = 30; lat_hi = 30; ready_pct = 100;
      exp_base = 26'h200; n_acc = 0; n_ret = 0; n_pop = 0;
      @(negedge iCLK);
      step();
      start = 1'b1; base_addr = 26'h200; word_count = 16'd10;
      k = 0;
      do begin
         @(negedge iCLK);
         start = 1'b0;
         step();
         k++;
      end while (n_acc < 3 && k < 50);
      check_eq("rst_setup", n_acc, 3);
      @(negedge iCLK);
      iRST = 1'b1; avl_readdatavalid = 1'b0;
      rsp_q.delete(); occ = 0; n_acc = 0; n_ret = 0; n_pop = 0; hold_pend = 0;
      #1;
      check_eq("midrst_busy", busy, 1'b0);
      check_eq("midrst_read", avl_read, 1'b0);
      check_eq("midrst_addr", avl_address, '0);
      check_eq("midrst_valid", rd_valid, 1'b0);
      @(negedge iCLK);
      iRST = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge iCLK);
         avl_readdatavalid = 1'b1;
         avl_readdata = data_of(26'h200 + ADDR_W'(i));
      end
      @(negedge iCLK);
      avl_readdatavalid = 1'b0;
      repeat (3) begin
         @(negedge iCLK);
         check_eq("stray_empty", rd_valid, 1'b0);
      end
      check_eq("stray_err", err_stray, 1'b1);
      $display("reset_mid strays=3 err_stray=%0b", err_stray);
      run_xfer(26'h300, 3, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "simulation time limit");
   end
endmodule
